// File: rtl/wishbone_master.sv
`default_nettype none
// ============================================================================
// Module  : wishbone_master
// Purpose : Wishbone classic-cycle burst master with a request/response front end
// Rev     : 1.0
// ============================================================================
module wishbone_master #(
    parameter int TAGSIZE   = 2,
    parameter int BURST_W   = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // request front end
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [31:0]        req_addr_i,
    input  logic               req_we_i,
    input  logic [3:0]         req_sel_i,
    input  logic [BURST_W-1:0] req_len_i,
    input  logic [TAGSIZE-1:0] req_tag_i,
    input  logic [31:0]        req_wdata_i,
    output logic               wdata_pop_o,
    output logic [31:0]        rdata_o,
    output logic               rdata_valid_o,
    output logic               done_o,
    output logic               err_o,
    // wishbone bus
    output logic [31:0]        wb_dat_o,
    input  logic [31:0]        wb_dat_i,
    output logic [TAGSIZE-1:0] wb_tgd_o,
    input  logic [TAGSIZE-1:0] wb_tgd_i,
    output logic [31:0]        wb_adr_o,
    output logic [TAGSIZE-1:0] wb_tga_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [TAGSIZE-1:0] wb_tgc_o,
    output logic [3:0]         wb_sel_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i
);

    localparam int c_retry_w = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int c_tmo_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int c_beat_w  = BURST_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BEAT    = 2'd1,
        S_RTYWAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [TAGSIZE-1:0]   tgc_q, tgc_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic [c_beat_w-1:0]  beats_q, beats_d;
    logic [c_retry_w-1:0] retry_q, retry_d;
    logic [c_tmo_w-1:0]   tmo_q, tmo_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 abort;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            tgc_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            beats_q  <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            tgc_q    <= tgc_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            beats_q  <= beats_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        sel_d       = sel_q;
        tgc_d       = tgc_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        beats_d     = beats_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wdata_pop_o = 1'b0;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    adr_d   = req_addr_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    tgc_d   = req_tag_i;
                    beats_d = {1'b0, req_len_i} + c_beat_w'(1);
                    retry_d = '0;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = S_BEAT;
                    if (req_we_i) begin
                        dat_d       = req_wdata_i;
                        wdata_pop_o = 1'b1;
                    end
                end
            end
            S_BEAT: begin
                if (wb_err_i) begin
                    abort = 1'b1;
                end else if (wb_rty_i) begin
                    if (retry_q < c_retry_w'(MAX_RETRY)) begin
                        retry_d = retry_q + c_retry_w'(1);
                        stb_d   = 1'b0;
                        state_d = S_RTYWAIT;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d  = wb_dat_i;
                        rvalid_d = 1'b1;
                    end
                    if (beats_q == c_beat_w'(1)) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // FIFO head is consumed as the next beat's data, so pop now
                        adr_d   = adr_q + 32'd4;
                        beats_d = beats_q - c_beat_w'(1);
                        retry_d = '0;
                        tmo_d   = '0;
                        if (we_q) begin
                            dat_d       = req_wdata_i;
                            wdata_pop_o = 1'b1;
                        end
                    end
                end else if (tmo_q == c_tmo_w'(TIMEOUT - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end
            S_RTYWAIT: begin
                stb_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_BEAT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
    end

    logic unused_tgd;
    assign unused_tgd = ^wb_tgd_i;

    assign req_ready_o   = (state_q == S_IDLE);
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign wb_dat_o      = dat_q;
    assign wb_tgd_o      = '0;
    assign wb_adr_o      = adr_q;
    assign wb_tga_o      = '0;
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_tgc_o      = tgc_q;
    assign wb_sel_o      = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master.sv
`default_nettype none
// Testbench for wishbone_master: scripted slave, transaction-level reference model.
module tb_wishbone_master;

    localparam int TAGSIZE   = 2;
    localparam int BURST_W   = 4;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;

    // slave response codes, two bits per strobed cycle; unused codes default to ACK
    localparam logic [1:0] R_ACK  = 2'd0;
    localparam logic [1:0] R_NONE = 2'd1;
    localparam logic [1:0] R_RTY  = 2'd2;
    localparam logic [1:0] R_ERR  = 2'd3;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [31:0]        req_addr_i;
    logic               req_we_i;
    logic [3:0]         req_sel_i;
    logic [BURST_W-1:0] req_len_i;
    logic [TAGSIZE-1:0] req_tag_i;
    logic [31:0]        req_wdata_i;
    logic               wdata_pop_o;
    logic [31:0]        rdata_o;
    logic               rdata_valid_o;
    logic               done_o;
    logic               err_o;
    logic [31:0]        wb_dat_o;
    logic [31:0]        wb_dat_i;
    logic [TAGSIZE-1:0] wb_tgd_o;
    logic [TAGSIZE-1:0] wb_tgd_i;
    logic [31:0]        wb_adr_o;
    logic [TAGSIZE-1:0] wb_tga_o;
    logic               wb_cyc_o;
    logic               wb_stb_o;
    logic               wb_we_o;
    logic [TAGSIZE-1:0] wb_tgc_o;
    logic [3:0]         wb_sel_o;
    logic               wb_ack_i;
    logic               wb_err_i;
    logic               wb_rty_i;

    always #5 clk_i = ~clk_i;

    wishbone_master #(
        .TAGSIZE(TAGSIZE), .BURST_W(BURST_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
        .req_tag_i(req_tag_i), .req_wdata_i(req_wdata_i), .wdata_pop_o(wdata_pop_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_tgd_o(wb_tgd_o), .wb_tgd_i(wb_tgd_i),
        .wb_adr_o(wb_adr_o), .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_tgc_o(wb_tgc_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    // burst context written by the stimulus process, read by the slave process
    int                 epoch = 0;
    logic [63:0]        script;
    logic [31:0]        wd_arr [17];
    logic               cur_we;
    logic [3:0]         cur_sel;
    logic [TAGSIZE-1:0] cur_tag;

    // observations, owned by the slave/monitor process
    int          epoch_seen = 0;
    int          sidx, widx;
    bit          pop_pending;
    int          obs_stb, obs_gaps, obs_pops, obs_done, obs_attr_err, obs_proto_err;
    logic        obs_err, obs_ready_at_done;
    logic [31:0] obs_adr[$], obs_dat[$], obs_rd[$];

    task automatic clear_obs();
        sidx = 0; widx = 0; pop_pending = 0;
        obs_stb = 0; obs_gaps = 0; obs_pops = 0; obs_done = 0;
        obs_attr_err = 0; obs_proto_err = 0; obs_err = 1'b0; obs_ready_at_done = 1'b0;
        obs_adr.delete(); obs_dat.delete(); obs_rd.delete();
        epoch_seen = epoch;
    endtask

    initial begin
        clear_obs();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        wb_dat_i = '0; wb_tgd_i = '0; req_wdata_i = '0;
    end

    always begin : slave
        logic [63:0] t;
        @(posedge clk_i); #1;
        if (epoch != epoch_seen) clear_obs();
        if (pop_pending) begin widx++; pop_pending = 0; end
        if (wb_stb_o && !wb_cyc_o) obs_proto_err++;
        if (err_o && !done_o) obs_proto_err++;
        if (wb_cyc_o && wb_stb_o) begin
            obs_stb++;
            obs_adr.push_back(wb_adr_o);
            obs_dat.push_back(wb_dat_o);
            if (wb_we_o !== cur_we || wb_sel_o !== cur_sel || wb_tgc_o !== cur_tag ||
                wb_tga_o !== '0 || wb_tgd_o !== '0) obs_attr_err++;
            t = script >> (2 * sidx);
            sidx++;
            wb_ack_i = (t[1:0] == R_ACK);
            wb_rty_i = (t[1:0] == R_RTY);
            wb_err_i = (t[1:0] == R_ERR);
            wb_dat_i = wb_ack_i ? rd_word(wb_adr_o) : $urandom;
        end else begin
            wb_ack_i = 1'b0; wb_rty_i = 1'b0; wb_err_i = 1'b0;
            wb_dat_i = $urandom;
        end
        wb_tgd_i = TAGSIZE'($urandom);
        if (wb_cyc_o && !wb_stb_o) obs_gaps++;
        if (rdata_valid_o) obs_rd.push_back(rdata_o);
        if (done_o) begin
            obs_done++;
            obs_err = err_o;
            obs_ready_at_done = req_ready_o;
        end
        @(negedge clk_i); #2;
        if (epoch != epoch_seen) clear_obs();
        if (wdata_pop_o) begin obs_pops++; pop_pending = 1; end
        req_wdata_i = wd_arr[widx];
    end

    // ---------------- reference model: burst outcome from the termination rules
    int          exp_stb, exp_gaps, exp_pops;
    logic        exp_err;
    logic [31:0] exp_adr[$], exp_dat[$], exp_rd[$];

    task automatic run_model(input logic [31:0] addr, input logic we,
                             input logic [BURST_W-1:0] len, input logic [63:0] scr);
        int n, i, retries, waitc, k;
        bit fin;
        logic [63:0] t;
        logic [31:0] a;
        n = int'(len) + 1; i = 0; retries = 0; waitc = 0; k = 0; fin = 0;
        exp_adr.delete(); exp_dat.delete(); exp_rd.delete();
        exp_stb = 0; exp_gaps = 0; exp_err = 1'b0;
        while (!fin) begin
            t = scr >> (2 * k);
            k++;
            exp_stb++;
            a = addr + 32'(4 * i);
            exp_adr.push_back(a);
            exp_dat.push_back(wd_arr[i]);
            case (t[1:0])
                R_ACK: begin
                    if (!we) exp_rd.push_back(rd_word(a));
                    i++; retries = 0; waitc = 0;
                    if (i == n) fin = 1;
                end
                R_NONE: begin
                    waitc++;
                    if (waitc == TIMEOUT) begin exp_err = 1'b1; fin = 1; end
                end
                R_RTY: begin
                    if (retries < MAX_RETRY) begin retries++; waitc = 0; exp_gaps++; end
                    else begin exp_err = 1'b1; fin = 1; end
                end
                default: begin exp_err = 1'b1; fin = 1; end
            endcase
        end
        exp_pops = !we ? 0 : (exp_err ? i + 1 : n);
    endtask

    // ---------------- stimulus helpers
    task automatic send_req(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                            input logic [BURST_W-1:0] len, input logic [TAGSIZE-1:0] tag);
        int g = 0;
        while (!req_ready_o && g < 100) begin @(negedge clk_i); g++; end
        if (!req_ready_o) check("req_ready_wait", 0, 1);
        req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
        req_sel_i = sel; req_len_i = len; req_tag_i = tag;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic start_burst(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                               input logic [BURST_W-1:0] len, input logic [TAGSIZE-1:0] tag,
                               input logic [63:0] scr);
        for (int i = 0; i < 17; i++) wd_arr[i] = (i <= int'(len)) ? $urandom : 32'h0;
        script = scr; cur_we = we; cur_sel = sel; cur_tag = tag;
        epoch++;
        send_req(addr, we, sel, len, tag);
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                             input logic [BURST_W-1:0] len, input logic [TAGSIZE-1:0] tag,
                             input logic [63:0] scr);
        int g = 0;
        int bad;
        start_burst(addr, we, sel, len, tag, scr);
        run_model(addr, we, len, scr);
        while (obs_done == 0 && g < 400) begin @(negedge clk_i); g++; end
        check("done_seen", 64'(obs_done != 0), 1);
        check("stb_cycles", 64'(obs_stb), 64'(exp_stb));
        bad = 0;
        for (int i = 0; i < obs_stb && i < exp_stb; i++) begin
            if (obs_adr[i] !== exp_adr[i]) bad++;
            if (we && obs_dat[i] !== exp_dat[i]) bad++;
        end
        check("beat_addr_data_mismatches", 64'(bad), 0);
        check("rdata_pulses", 64'(obs_rd.size()), 64'(exp_rd.size()));
        bad = 0;
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            if (obs_rd[i] !== exp_rd[i]) bad++;
        check("rdata_value_mismatches", 64'(bad), 0);
        check("wdata_pops", 64'(obs_pops), 64'(exp_pops));
        check("stb_gaps", 64'(obs_gaps), 64'(exp_gaps));
        check("done_count", 64'(obs_done), 1);
        check("err_o", 64'(obs_err), 64'(exp_err));
        check("ready_at_done", 64'(obs_ready_at_done), 1);
        check("bus_attr_errors", 64'(obs_attr_err), 0);
        check("protocol_errors", 64'(obs_proto_err), 0);
        check("cyc_after_done", 64'({wb_cyc_o, wb_stb_o}), 0);
    endtask

    typedef struct {
        logic [31:0]        addr;
        logic               we;
        logic [3:0]         sel;
        logic [BURST_W-1:0] len;
        logic [TAGSIZE-1:0] tag;
        logic [63:0]        scr;
        logic               exp_err;
        int                 exp_stb;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        logic [63:0] scr;
        rst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
        req_sel_i = '0; req_len_i = '0; req_tag_i = '0;
        script = '0; cur_we = 1'b0; cur_sel = '0; cur_tag = '0;
        for (int i = 0; i < 17; i++) wd_arr[i] = '0;

        vecs[0] = '{32'h0000_0100, 1'b0, 4'hF, 4'd0,  2'd1, 64'h0,        1'b0, 1};
        vecs[1] = '{32'hFFFF_FFF8, 1'b1, 4'hF, 4'd3,  2'd2, 64'h0,        1'b0, 4};
        vecs[2] = '{32'h0000_2000, 1'b0, 4'h3, 4'd0,  2'd3, 64'hA,        1'b0, 3};
        vecs[3] = '{32'h0000_3000, 1'b0, 4'hC, 4'd0,  2'd0, 64'hAA,       1'b1, 4};
        vecs[4] = '{32'h0000_4000, 1'b0, 4'hF, 4'd0,  2'd1, 64'h5555_5555, 1'b1, 16};
        vecs[5] = '{32'h0000_5000, 1'b0, 4'hF, 4'd3,  2'd2, 64'h30,       1'b1, 3};
        vecs[6] = '{32'h0000_6000, 1'b1, 4'h5, 4'd15, 2'd3, 64'h0,        1'b0, 16};
        vecs[7] = '{32'h0000_7000, 1'b1, 4'hF, 4'd1,  2'd0, 64'h1555_5555, 1'b0, 17};
        vecs[8] = '{32'h0000_8000, 1'b0, 4'hF, 4'd1,  2'd1, 64'h2A,       1'b0, 5};

        repeat (3) @(negedge clk_i);
        check("rst_held_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("reset_ready", 64'(req_ready_o), 1);
        check("reset_flags", 64'({done_o, err_o, rdata_valid_o, wdata_pop_o, wb_we_o}), 0);
        check("reset_adr_dat", {wb_adr_o, wb_dat_o}, 0);
        check("reset_rdata", 64'(rdata_o), 0);

        for (int v = 0; v < 9; v++) begin
            run_burst(vecs[v].addr, vecs[v].we, vecs[v].sel, vecs[v].len, vecs[v].tag, vecs[v].scr);
            check($sformatf("vec%0d_err", v), 64'(obs_err), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_stb", v), 64'(obs_stb), 64'(vecs[v].exp_stb));
            if (v == 0) check("single_read_data", 64'(obs_rd.size() > 0 ? obs_rd[0] : 32'h0),
                              64'h0000_0000_DEAD_BEEF);
        end

        // reset while beat 1 of a read burst is on the bus
        start_burst(32'h0000_9000, 1'b0, 4'hF, 4'd3, 2'd2, 64'h5555_5555_5555_5554);
        begin
            int g = 0;
            while (obs_stb < 2 && g < 50) begin @(negedge clk_i); g++; end
        end
        check("midburst_beat1_reached", 64'(obs_stb >= 2), 1);
        epoch++;
        rst_i = 1'b0;
        #1;
        check("midburst_reset_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("after_reset_ready", 64'(req_ready_o), 1);
        check("after_reset_no_done", 64'(obs_done), 0);

        for (int r = 0; r < 40; r++) begin
            logic [31:0] a;
            int sel_r;
            for (int k = 0; k < 32; k++) begin
                sel_r = $urandom_range(0, 19);
                scr[2*k +: 2] = (sel_r < 14) ? R_ACK : (sel_r < 17) ? R_NONE :
                                (sel_r < 19) ? R_RTY : R_ERR;
            end
            if ($urandom_range(0, 7) == 0) scr[31:0] = 32'h5555_5555;
            a = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFC0 | (a & 32'h0000_003C);
            run_burst(a, 1'($urandom), 4'($urandom), BURST_W'($urandom), TAGSIZE'($urandom), scr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
